// File: rtl/mem_stage_unit_pkg.sv
// Shared types and widths for the memory stage: FSM states, EX/MEM and MEM/WB
// field widths, flag bit positions.
package mem_stage_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W1   = 2'd1,
    W2   = 2'd2
  } state_e;

  localparam int DATA_W     = 32;
  localparam int WORD_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int FLAG_W     = 3;
  localparam int EXMEM_W    = 2*DATA_W + REG_ADDR_W + 6 + FLAG_W;
  localparam int MEMWB_W    = 1 + REG_ADDR_W + WORD_W;

  localparam int FLAG_ZF = 0;
  localparam int FLAG_CF = 1;
  localparam int FLAG_NF = 2;

  // Flags are stored on the stack zero-extended to a full word.
  function automatic logic [WORD_W-1:0] flags_word(input logic [FLAG_W-1:0] f);
    return {{(WORD_W-FLAG_W){1'b0}}, f};
  endfunction

endpackage

// File: rtl/mem_stage_unit_data_memory.sv
// 16-bit-word data RAM: async read, sync write.
module data_memory
  import mem_stage_unit_pkg::*;
#(
  parameter int    ADDR_W    = 12,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_unit.sv
// Memory stage: single-cycle loads/stores plus a 3-state FSM sequencing PC and
// interrupt stack frames. Optional MEM_BOUNDS_CHECK_EN adds Mem_Exception.
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int    ADDR_W    = 12,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     Data,
  input  logic [DATA_W-1:0]     Address,
  input  logic [REG_ADDR_W-1:0] WB_Address,
  input  logic                  MR,
  input  logic                  MW,
  input  logic                  WB,
  input  logic                  JWSP,
  input  logic                  Stack_PC,
  input  logic                  Stack_Flags,
  input  logic [FLAG_W-1:0]     Final_Flags,
  output logic                  Stall,
  output logic                  WB_Out,
  output logic [REG_ADDR_W-1:0] WB_Address_Out,
  output logic [WORD_W-1:0]     WB_Data,
  output logic                  PC_Load,
  output logic [DATA_W-1:0]     PC_From_Memory,
  output logic                  Flags_Load,
  output logic [FLAG_W-1:0]     Flags_From_Memory
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic                  Mem_Exception
`endif
);

  state_e              st_q, st_d;
  logic [ADDR_W-1:0]   a_in, fr_addr_q, fr_addr_d, mem_addr;
  logic [WORD_W-1:0]   fr_hi_q, fr_hi_d, mem_wdata, mem_rdata, rdata;
  logic [FLAG_W-1:0]   fr_flags_q, fr_flags_d;
  logic                fr_push_q, fr_push_d, fr_flg_q, fr_flg_d, fr_oob_q, fr_oob_d;
  logic                mem_we, dmem_we, stall_c, oob, oob_in;
  logic                start_push, start_pop;

  logic                  wb_out_d, pc_load_d, fl_load_d;
  logic [REG_ADDR_W-1:0] wb_addr_d;
  logic [WORD_W-1:0]     wb_data_d;
  logic [DATA_W-1:0]     pc_d;
  logic [FLAG_W-1:0]     fl_d;

  assign a_in = Address[ADDR_W-1:0];

  // With both MR and MW on a PC-frame op, JWSP picks the push path.
  assign start_push = Stack_PC & MW & (~MR | JWSP);
  assign start_pop  = Stack_PC & MR & ~start_push;

`ifdef MEM_BOUNDS_CHECK_EN
  logic exc_d, exc_q;
  assign oob_in = |Address[DATA_W-1:ADDR_W];
  assign oob    = (st_q == IDLE) ? oob_in : fr_oob_q;
  assign exc_d  = oob & ((st_q != IDLE) | MR | MW);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) exc_q <= 1'b0;
    else     exc_q <= exc_d;
  end
  assign Mem_Exception = exc_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |Address[DATA_W-1:ADDR_W];
  assign oob_in = 1'b0;
  assign oob    = 1'b0;
`endif

  assign rdata   = oob ? '0 : mem_rdata;
  assign dmem_we = mem_we & ~oob & ~rst;

  data_memory #(.ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE)) u_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    st_d       = st_q;
    fr_addr_d  = fr_addr_q;
    fr_hi_d    = fr_hi_q;
    fr_flags_d = fr_flags_q;
    fr_push_d  = fr_push_q;
    fr_flg_d   = fr_flg_q;
    fr_oob_d   = fr_oob_q;
    mem_we     = 1'b0;
    mem_addr   = a_in;
    mem_wdata  = Data[WORD_W-1:0];
    stall_c    = 1'b0;
    wb_out_d   = 1'b0;
    wb_addr_d  = WB_Address_Out;
    wb_data_d  = WB_Data;
    pc_load_d  = 1'b0;
    pc_d       = PC_From_Memory;
    fl_load_d  = 1'b0;
    fl_d       = Flags_From_Memory;

    unique case (st_q)
      IDLE: begin
        wb_addr_d = WB_Address;
        wb_data_d = Data[WORD_W-1:0];
        if (start_push | start_pop) begin
          fr_addr_d  = a_in;
          fr_push_d  = start_push;
          fr_flg_d   = Stack_Flags;
          fr_oob_d   = oob_in;
          stall_c    = 1'b1;
          st_d       = W1;
          if (start_push) begin
            mem_we     = 1'b1;
            fr_hi_d    = Data[DATA_W-1:WORD_W];
            fr_flags_d = Final_Flags;
          end else if (Stack_Flags) begin
            fr_flags_d = rdata[FLAG_W-1:0];
          end else begin
            fr_hi_d    = rdata;
          end
        end else begin
          mem_we   = MW;
          wb_out_d = WB & ~(MR & MW);
          if (MR & ~MW) begin
            wb_data_d = rdata;
            if (Stack_Flags) begin
              fl_load_d = 1'b1;
              fl_d      = rdata[FLAG_W-1:0];
            end
          end
        end
      end

      W1: begin
        if (fr_push_q) begin
          mem_addr  = fr_addr_q - ADDR_W'(1);
          mem_we    = 1'b1;
          mem_wdata = fr_hi_q;
          st_d      = fr_flg_q ? W2 : IDLE;
        end else if (fr_flg_q) begin
          mem_addr = fr_addr_q + ADDR_W'(1);
          fr_hi_d  = rdata;
          st_d     = W2;
        end else begin
          mem_addr  = fr_addr_q + ADDR_W'(1);
          pc_load_d = 1'b1;
          pc_d      = {fr_hi_q, rdata};
          st_d      = IDLE;
        end
        stall_c = fr_flg_q;
      end

      W2: begin
        if (fr_push_q) begin
          mem_addr  = fr_addr_q - ADDR_W'(2);
          mem_we    = 1'b1;
          mem_wdata = flags_word(fr_flags_q);
        end else begin
          mem_addr  = fr_addr_q + ADDR_W'(2);
          pc_load_d = 1'b1;
          pc_d      = {fr_hi_q, rdata};
          fl_load_d = 1'b1;
          fl_d      = fr_flags_q;
        end
        st_d = IDLE;
      end

      default: st_d = IDLE;
    endcase
  end

  assign Stall = stall_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q              <= IDLE;
      fr_addr_q         <= '0;
      fr_hi_q           <= '0;
      fr_flags_q        <= '0;
      fr_push_q         <= 1'b0;
      fr_flg_q          <= 1'b0;
      fr_oob_q          <= 1'b0;
      WB_Out            <= 1'b0;
      WB_Address_Out    <= '0;
      WB_Data           <= '0;
      PC_Load           <= 1'b0;
      PC_From_Memory    <= '0;
      Flags_Load        <= 1'b0;
      Flags_From_Memory <= '0;
    end else begin
      st_q              <= st_d;
      fr_addr_q         <= fr_addr_d;
      fr_hi_q           <= fr_hi_d;
      fr_flags_q        <= fr_flags_d;
      fr_push_q         <= fr_push_d;
      fr_flg_q          <= fr_flg_d;
      fr_oob_q          <= fr_oob_d;
      WB_Out            <= wb_out_d;
      WB_Address_Out    <= wb_addr_d;
      WB_Data           <= wb_data_d;
      PC_Load           <= pc_load_d;
      PC_From_Memory    <= pc_d;
      Flags_Load        <= fl_load_d;
      Flags_From_Memory <= fl_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: vector table for single-cycle ops,
// hand sequences for stack frames, wrap and mid-op reset, with a scoreboard queue.
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Data, Address;
  logic [2:0]  WB_Address, Final_Flags;
  logic        MR, MW, WB, JWSP, Stack_PC, Stack_Flags;
  logic        Stall, WB_Out, PC_Load, Flags_Load;
  logic [2:0]  WB_Address_Out, Flags_From_Memory;
  logic [15:0] WB_Data;
  logic [31:0] PC_From_Memory;
`ifdef MEM_BOUNDS_CHECK_EN
  logic        mem_exc;
`endif

  mem_stage_unit #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .Data(Data), .Address(Address), .WB_Address(WB_Address),
    .MR(MR), .MW(MW), .WB(WB), .JWSP(JWSP), .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags),
    .Final_Flags(Final_Flags), .Stall(Stall), .WB_Out(WB_Out), .WB_Address_Out(WB_Address_Out),
    .WB_Data(WB_Data), .PC_Load(PC_Load), .PC_From_Memory(PC_From_Memory),
    .Flags_Load(Flags_Load), .Flags_From_Memory(Flags_From_Memory)
`ifdef MEM_BOUNDS_CHECK_EN
    , .Mem_Exception(mem_exc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mr, mw, wb, sf;
    logic [2:0] wba;
    logic [31:0] addr, data;
    logic eo;
    logic [2:0] ewba;
    logic [15:0] ed;
    logic efl;
    logic [2:0] ef;
  } vec_t;

  typedef struct {
    string nm;
    logic chk_wb, wbo;
    logic [2:0] wba;
    logic [15:0] wbd;
    logic pcl;
    logic [31:0] pc;
    logic fll;
    logic [2:0] fl;
  } exp_t;

  exp_t exp_q[$];
  vec_t vt[8];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic expect_(input string nm, input logic cw, input logic wbo, input logic [2:0] wba,
                         input logic [15:0] wbd, input logic pcl, input logic [31:0] pc,
                         input logic fll, input logic [2:0] fl);
    exp_t e;
    e.nm = nm; e.chk_wb = cw; e.wbo = wbo; e.wba = wba; e.wbd = wbd;
    e.pcl = pcl; e.pc = pc; e.fll = fll; e.fl = fl;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.nm, ".wb_out"}, WB_Out, e.wbo);
      chk({e.nm, ".pc_load"}, PC_Load, e.pcl);
      chk({e.nm, ".flags_load"}, Flags_Load, e.fll);
      if (e.chk_wb) begin
        chk({e.nm, ".wb_addr"}, WB_Address_Out, e.wba);
        chk({e.nm, ".wb_data"}, WB_Data, e.wbd);
      end
      if (e.pcl) chk({e.nm, ".pc"}, PC_From_Memory, e.pc);
      if (e.fll) chk({e.nm, ".flags"}, Flags_From_Memory, e.fl);
    end
  endtask

  task automatic drv(input logic mr, input logic mw, input logic wb, input logic spc,
                     input logic sf, input logic [2:0] wba, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] ff);
    MR = mr; MW = mw; WB = wb; Stack_PC = spc; Stack_Flags = sf; JWSP = 1'b0;
    WB_Address = wba; Address = a; Data = d; Final_Flags = ff;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 3'd0);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [15:0] exp, input logic [2:0] wba);
    drv(1, 0, 1, 0, 0, wba, a, 32'd0, 3'd0);
    expect_(nm, 1, 1, wba, exp, 0, 0, 0, 0);
    #1 chk({nm, ".stall"}, Stall, 1'b0);
    tick();
    idle();
  endtask

  // Drives a PC-frame op and walks it; stall_seq[k] is the expected Stall in cycle k.
  task automatic frame(input string nm, input logic mr, input logic mw, input logic sf,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] ff,
                       input int ncyc, input logic pop_done, input logic [31:0] pc,
                       input logic [2:0] fl);
    drv(mr, mw, 1, 1, sf, 3'd6, a, d, ff);
    for (int k = 0; k < ncyc; k++) begin
      #1 chk($sformatf("%s.stall%0d", nm, k), Stall, (k < ncyc-1));
      if (k == ncyc-1 && pop_done) expect_(nm, 0, 0, 0, 0, 1, pc, sf, fl);
      else                         expect_(nm, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            mr mw wb sf wba  addr          data          eo ewba ed       efl ef
    vt[0] = '{0, 1, 0, 0, 3'd0, 32'h010,      32'h0000BEEF, 0, 3'd0, 16'hBEEF, 0, 3'd0};
    vt[1] = '{1, 0, 1, 0, 3'd3, 32'h010,      32'h0,        1, 3'd3, 16'hBEEF, 0, 3'd0};
    vt[2] = '{0, 1, 0, 0, 3'd0, 32'h020,      32'h12340007, 0, 3'd0, 16'h0007, 0, 3'd0};
    vt[3] = '{1, 0, 0, 1, 3'd0, 32'h020,      32'h0,        0, 3'd0, 16'h0007, 1, 3'b111};
    vt[4] = '{1, 1, 1, 0, 3'd2, 32'h010,      32'h00005555, 0, 3'd2, 16'h5555, 0, 3'd0};
    vt[5] = '{1, 0, 1, 0, 3'd5, 32'h010,      32'h0,        1, 3'd5, 16'h5555, 0, 3'd0};
    vt[6] = '{0, 0, 1, 0, 3'd7, 32'h0,        32'hFFFFA5A5, 1, 3'd7, 16'hA5A5, 0, 3'd0};
`ifdef MEM_BOUNDS_CHECK_EN
    vt[7] = '{1, 0, 1, 0, 3'd1, 32'h00001010, 32'h0,        1, 3'd1, 16'h0000, 0, 3'd0};
`else
    vt[7] = '{1, 0, 1, 0, 3'd1, 32'h00001010, 32'h0,        1, 3'd1, 16'h5555, 0, 3'd0};
`endif

    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.stall", Stall, 0);
    chk("reset.wb_out", WB_Out, 0);
    chk("reset.wb_data", WB_Data, 0);
    chk("reset.pc_load", PC_Load, 0);
    chk("reset.flags_load", Flags_Load, 0);
    chk("reset.pc", PC_From_Memory, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      drv(vt[i].mr, vt[i].mw, vt[i].wb, 0, vt[i].sf, vt[i].wba, vt[i].addr, vt[i].data, 3'd0);
      expect_($sformatf("vec%0d", i), 1, vt[i].eo, vt[i].ewba, vt[i].ed, 0, 0, vt[i].efl, vt[i].ef);
      #1 chk($sformatf("vec%0d.stall", i), Stall, 0);
      tick();
    end
    idle();
    tick();

    // CALL push with address at top of memory
    frame("call", 0, 1, 0, 32'h0FFF, 32'h00012345, 3'd0, 2, 0, 0, 0);
    rd("call_lo", 32'h0FFF, 16'h2345, 3'd1);
    rd("call_hi", 32'h0FFE, 16'h0001, 3'd1);

    // Interrupt push then RTI pop of the same frame
    frame("int_push", 0, 1, 1, 32'h0FFF, 32'h00ABCDEF, 3'b101, 3, 0, 0, 0);
    rd("int_flags", 32'h0FFD, 16'h0005, 3'd2);
    frame("rti", 1, 0, 1, 32'h0FFD, 32'h0, 3'd0, 3, 1, 32'h00ABCDEF, 3'b101);
    expect_("rti_after", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rti.pc_hold", PC_From_Memory, 32'h00ABCDEF);
    chk("rti.flags_hold", Flags_From_Memory, 3'b101);

    // Push at address 0 wraps the high word to the top; pop wraps back
    frame("wrap_push", 0, 1, 0, 32'h0000, 32'hBEEF1234, 3'd0, 2, 0, 0, 0);
    rd("wrap_hi", 32'h0FFF, 16'hBEEF, 3'd4);
    rd("wrap_lo", 32'h0000, 16'h1234, 3'd4);
    frame("wrap_pop", 1, 0, 0, 32'h0FFF, 32'h0, 3'd0, 2, 1, 32'hBEEF1234, 3'd0);

    // Reset while in W1 of a push: only the low word lands
    drv(0, 1, 0, 0, 0, 3'd0, 32'h0100, 32'h0000AAAA, 3'd0);
    tick();
    drv(0, 1, 1, 1, 0, 3'd0, 32'h0101, 32'h99998888, 3'd0);
    expect_("rstw1_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("rstw1.stall", Stall, 0);
    chk("rstw1.wb_data", WB_Data, 0);
    chk("rstw1.pc", PC_From_Memory, 0);
    chk("rstw1.flags", Flags_From_Memory, 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    rd("rstw1_hi_kept", 32'h0100, 16'hAAAA, 3'd5);
    rd("rstw1_lo", 32'h0101, 16'h8888, 3'd5);
    frame("post_push", 0, 1, 0, 32'h0200, 32'h11112222, 3'd0, 2, 0, 0, 0);
    frame("post_pop", 1, 0, 0, 32'h01FF, 32'h0, 3'd0, 2, 1, 32'h11112222, 3'd0);

`ifdef MEM_BOUNDS_CHECK_EN
    drv(0, 1, 0, 0, 0, 3'd0, 32'h00010010, 32'h00007777, 3'd0);
    tick();
    chk("oob.exc", mem_exc, 1);
    idle();
    tick();
    chk("oob.exc_clear", mem_exc, 0);
    rd("oob_nowrite", 32'h0010, 16'h5555, 3'd1);
`endif

    idle();
    tick();
    chk("final.queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
